// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter for the write port of the dual-clock FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int MAXBURST  = 4
) (
    input  logic                      iWCLK,
    input  logic                      iWRST,
    input  logic [NREQ-1:0]           iREQ,
    input  logic [NREQ*DATAWIDTH-1:0] iDAT,
    input  logic [NREQ-1:0]           iLAST,
    output logic [NREQ-1:0]           oACK,
    input  logic                      iFULL,
    output logic                      oWINC,
    output logic [DATAWIDTH-1:0]      oWDAT,
    output logic [NREQ-1:0]           oGNT,
    output logic                      oBUSY
);

    localparam int c_GIDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CNT_W  = (MAXBURST > 1) ? $clog2(MAXBURST + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAXBURST - 1);
    localparam logic [NREQ-1:0]    c_ONE_HOT0 = NREQ'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                r_state,  w_stateNxt;
    logic [NREQ-1:0]       r_gnt,    w_gntNxt;
    logic [c_GIDX_W-1:0]   r_gidx,   w_gidxNxt;
    logic [c_GIDX_W-1:0]   r_rr,     w_rrNxt;
    logic [c_CNT_W-1:0]    r_cnt,    w_cntNxt;

    logic                  w_pickValid;
    logic [c_GIDX_W-1:0]   w_pickIdx;
    logic                  w_acc;
    logic                  w_release;
    logic [DATAWIDTH-1:0]  w_slice [NREQ];

    // (base + off) mod NREQ, with off < NREQ so a single subtraction suffices
    function automatic logic [c_GIDX_W-1:0] wrapAdd(input logic [c_GIDX_W-1:0] base,
                                                    input int                  off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return c_GIDX_W'(s);
    endfunction

    generate
        for (genvar k = 0; k < NREQ; k++) begin : g_slice
            assign w_slice[k] = iDAT[k*DATAWIDTH +: DATAWIDTH];
        end
    endgenerate

    // Scan from the highest offset down so the requester nearest rr wins
    always_comb begin
        w_pickValid = 1'b0;
        w_pickIdx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (iREQ[wrapAdd(r_rr, i)]) begin
                w_pickValid = 1'b1;
                w_pickIdx   = wrapAdd(r_rr, i);
            end
        end
    end

    always_comb begin
        w_stateNxt = r_state;
        w_gntNxt   = r_gnt;
        w_gidxNxt  = r_gidx;
        w_rrNxt    = r_rr;
        w_cntNxt   = r_cnt;
        w_acc      = 1'b0;
        w_release  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pickValid) begin
                    w_stateNxt = ST_BURST;
                    w_gntNxt   = c_ONE_HOT0 << w_pickIdx;
                    w_gidxNxt  = w_pickIdx;
                    w_cntNxt   = '0;
                end
            end
            ST_BURST: begin
                w_acc = iREQ[r_gidx] & ~iFULL;
                if (w_acc) begin
                    w_cntNxt = c_CNT_W'(r_cnt + 1'b1);
                end
                // A stall on full alone never releases; only LAST, the cap or a withdraw do
                w_release = (w_acc & (iLAST[r_gidx] | (r_cnt == c_CNT_LAST)))
                          | ~iREQ[r_gidx];
                if (w_release) begin
                    w_stateNxt = ST_IDLE;
                    w_gntNxt   = '0;
                    w_rrNxt    = wrapAdd(r_gidx, 1);
                end
            end
            default: begin
                w_stateNxt = ST_IDLE;
                w_gntNxt   = '0;
            end
        endcase
    end

    always_ff @(posedge iWCLK or posedge iWRST) begin
        if (iWRST) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_rr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNxt;
            r_gnt   <= w_gntNxt;
            r_gidx  <= w_gidxNxt;
            r_rr    <= w_rrNxt;
            r_cnt   <= w_cntNxt;
        end
    end

    // Write strobes are gated by reset directly so they drop within the reset cycle
    assign oWINC = w_acc & ~iWRST;
    assign oACK  = oWINC ? r_gnt : '0;
    assign oWDAT = w_slice[r_gidx];
    assign oGNT  = r_gnt;
    assign oBUSY = (r_state == ST_BURST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed and random checks of fifo_wr_arbiter against a burst model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;

    logic              iWCLK = 1'b0;
    logic              iWRST = 1'b1;
    logic [NR-1:0]     iREQ  = '0;
    logic [NR*DW-1:0]  iDAT  = '0;
    logic [NR-1:0]     iLAST = '0;
    logic              iFULL = 1'b0;
    logic [NR-1:0]     oACK;
    logic              oWINC;
    logic [DW-1:0]     oWDAT;
    logic [NR-1:0]     oGNT;
    logic              oBUSY;

    int errors = 0;
    int checks = 0;

    // Burst-level model: who owns the port, words taken so far, next search start
    bit mBusy = 1'b0;
    int mG    = 0;
    int mCnt  = 0;
    int mRr   = 0;
    int wrLog[$];

    fifo_wr_arbiter #(.DATAWIDTH(DW), .NREQ(NR), .MAXBURST(MB)) dut (
        .iWCLK (iWCLK),
        .iWRST (iWRST),
        .iREQ  (iREQ),
        .iDAT  (iDAT),
        .iLAST (iLAST),
        .oACK  (oACK),
        .iFULL (iFULL),
        .oWINC (oWINC),
        .oWDAT (oWDAT),
        .oGNT  (oGNT),
        .oBUSY (oBUSY)
    );

    always #5 iWCLK = ~iWCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs applied; checks, advances the model, waits one cycle
    task automatic cycle();
        bit acc;
        logic [31:0] expGnt;
        #1;
        acc    = 1'b0;
        expGnt = 0;
        if (!iWRST && mBusy) begin
            acc    = iREQ[mG] && !iFULL;
            expGnt = 32'(1) << mG;
        end
        chk("winc", 32'(oWINC), 32'(acc));
        chk("ack", 32'(oACK), acc ? expGnt : 32'd0);
        chk("gnt", 32'(oGNT), expGnt);
        chk("busy", 32'(oBUSY), 32'(mBusy && !iWRST));
        chk("full_gate", 32'(oWINC & iFULL), 32'd0);
        if (acc) begin
            chk("wdat", 32'(oWDAT), (iDAT >> (mG * DW)) & 32'hFF);
        end
        for (int k = 0; k < NR; k++) begin
            if (oWINC && oACK[k]) wrLog.push_back(k);
        end
        if (iWRST) begin
            mBusy = 1'b0;
            mRr   = 0;
            mCnt  = 0;
        end else if (!mBusy) begin
            for (int i = 0; i < NR; i++) begin
                if (iREQ[(mRr + i) % NR]) begin
                    mG    = (mRr + i) % NR;
                    mBusy = 1'b1;
                    mCnt  = 0;
                    break;
                end
            end
        end else begin
            if (acc) mCnt++;
            if ((acc && (iLAST[mG] || mCnt == MB)) || !iREQ[mG]) begin
                mBusy = 1'b0;
                mRr   = (mG + 1) % NR;
            end
        end
        @(posedge iWCLK);
        @(negedge iWCLK);
    endtask

    initial begin
        int expOrder[5];
        expOrder = '{0, 1, 2, 3, 0};

        // Reset state
        cycle();
        cycle();
        iWRST = 1'b0;

        // Move rr to 2 with a single-word burst from req1
        iREQ = 4'b0010; iLAST = 4'b0010; iDAT = $urandom;
        cycle();
        cycle();
        iREQ = '0;
        cycle();

        // req3 burst, two words taken, then reset lands mid-cycle
        iREQ = 4'b1000; iLAST = '0;
        cycle();
        iDAT = $urandom; cycle();
        iDAT = $urandom; cycle();
        #2 iWRST = 1'b1;
        cycle();
        iWRST = 1'b0;

        // Round robin from the reset pointer: 0,1,2,3,0
        wrLog.delete();
        iREQ = 4'b1111; iLAST = 4'b1111;
        for (int n = 0; n < 10; n++) begin
            iDAT = $urandom;
            cycle();
        end
        chk("rr_count", 32'(wrLog.size()), 32'd5);
        for (int n = 0; n < 5 && n < wrLog.size(); n++) begin
            chk("rr_order", 32'(wrLog[n]), 32'(expOrder[n]));
        end

        // Burst cap: req2 alone with no LAST
        iREQ = '0;
        cycle();
        wrLog.delete();
        iREQ = 4'b0100; iLAST = '0;
        for (int n = 0; n < 10; n++) begin
            iDAT = $urandom;
            cycle();
        end
        chk("cap_writes", 32'(wrLog.size()), 32'd8);

        // Full stall at cnt=1, burst still ends after MAXBURST words
        iREQ = '0;
        cycle();
        wrLog.delete();
        iREQ = 4'b0001;
        cycle();
        iDAT = $urandom; cycle();
        iFULL = 1'b1;
        for (int n = 0; n < 3; n++) cycle();
        iFULL = 1'b0;
        for (int n = 0; n < 4; n++) begin
            iDAT = $urandom;
            cycle();
        end
        chk("stall_writes", 32'(wrLog.size()), 32'd4);
        iREQ = '0;
        cycle();

        // Withdraw: req1 granted then drops, pointer must advance to 2
        wrLog.delete();
        iREQ = 4'b0010;
        cycle();
        iREQ = '0;
        cycle();
        chk("withdraw_writes", 32'(wrLog.size()), 32'd0);
        iREQ = 4'b1111; iLAST = 4'b1111;
        cycle();
        chk("withdraw_next_gnt", 32'(oGNT), 32'h4);
        iREQ = '0;
        cycle();
        cycle();

        // Random traffic including occasional resets
        for (int n = 0; n < 400; n++) begin
            iREQ  = NR'($urandom_range(0, 15));
            iLAST = NR'($urandom_range(0, 15));
            iFULL = ($urandom_range(0, 3) == 0);
            iDAT  = $urandom;
            iWRST = ($urandom_range(0, 79) == 0);
            cycle();
        end
        iWRST = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
